shift_stage: RTL and testbench

SHIFT_STAGE -- requirements
Module: shift_stage

---
 rtl/shift_pkg.sv | 29 ++
 rtl/sll.sv | 22 ++
 rtl/shift_stage.sv | 140 ++++++++++++++
 tb/tb_shift_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift execution stage: operand widths, op
// encoding, the buffered result entry and a bit-reversal helper.
package shift_pkg;

  localparam int XLEN       = 32;
  localparam int SHAMT_W    = 5;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] rd_addr;
  } entry_t;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sll.sv
// Combinational logarithmic left shifter with zero fill; stage i shifts by
// 2**i when shamt[i] is set.
module sll
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    result
);

  logic [XLEN-1:0] stage [SHAMT_W+1];

  assign stage[0] = data;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int SH = 1 << i;
    assign stage[i+1] = shamt[i] ? {stage[i][XLEN-1-SH:0], {SH{1'b0}}} : stage[i];
  end

  assign result = stage[SHAMT_W];

endmodule

// File: rtl/shift_stage.sv
// Shift execution stage: one shared left shifter serves SLL/SRL/SRA through
// reversal/inversion muxes, with results queued in a small in-order buffer.
module shift_stage
  import shift_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [XLEN-1:0]       i_operand_a,
  input  logic [XLEN-1:0]       i_operand_b,
  input  logic [1:0]            i_op,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       o_result,
  output logic [REG_ADDR_W-1:0] o_rd_addr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  shift_op_e       op;
  logic            invert;
  logic [XLEN-1:0] pre;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] result;
  logic            unused_b_hi;

  assign op          = shift_op_e'(i_op);
  assign unused_b_hi = ^i_operand_b[XLEN-1:SHAMT_W];
  // An arithmetic right shift of a negative value is the complement of a
  // logical right shift of the complemented value.
  assign invert      = (op == SHIFT_SRA) && i_operand_a[XLEN-1];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pre = i_operand_a;
    case (op)
      SHIFT_SRL: pre = bit_rev(i_operand_a);
      SHIFT_SRA: pre = bit_rev(invert ? ~i_operand_a : i_operand_a);
      default:   pre = i_operand_a;
    endcase
  end

  sll u_sll (
    .data   (pre),
    .shamt  (i_operand_b[SHAMT_W-1:0]),
    .result (shifted)
  );

  always_comb begin
    result = i_operand_a;
    case (op)
      SHIFT_SLL: result = shifted;
      SHIFT_SRL: result = bit_rev(shifted);
      SHIFT_SRA: result = invert ? ~bit_rev(shifted) : bit_rev(shifted);
      default:   result = i_operand_a;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------------
  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head_nxt;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             accept, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_ready   = (count < CNT_W'(DEPTH));
  assign accept    = i_valid && o_ready && !i_flush;
  assign pop       = o_valid && i_ready && !i_flush;
  assign new_entry = '{result: result, rd_addr: i_rd_addr};

  always_comb begin
    rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
    count_nxt  = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    // The next head is the entry being written this edge when the read
    // pointer lands on the write slot (empty buffer, or accept+pop at one).
    head_nxt = (accept && (rd_ptr_nxt == wr_ptr)) ? new_entry : mem[rd_ptr_nxt];
  end

  // NOTE: storage carries no reset; its contents are only observed through
  // count/pointers, which are reset, so clearing the array buys nothing.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // Reset is synchronous: it is sampled here on the clock edge, never in the
  // sensitivity list, so no output moves asynchronously with i_rst_n.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_rd_addr <= '0;
    end else if (i_flush) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      o_valid <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      o_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        o_result  <= head_nxt.result;
        o_rd_addr <= head_nxt.rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_shift_stage.sv
// Scoreboard bench for shift_stage: driver pushes model results on accept,
// a monitor pops and compares whenever the stage hands a result downstream.
module tb_shift_stage;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic [1:0]  i_op;
  logic [4:0]  i_rd_addr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;

  shift_stage #(.DEPTH(2)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .i_op        (i_op),
    .i_rd_addr   (i_rd_addr),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_rd_addr   (o_rd_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the shift definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      2'd0:    return a << sh;
      2'd1:    return a >> sh;
      2'd2:    return 32'($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  // Inputs change on the falling edge; the scoreboard is updated after the
  // monitor has looked at this cycle's outputs.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [4:0] rd,
                       input logic rdy, input logic fl, input logic rn);
    @(negedge i_clk);
    i_valid     = v;
    i_operand_a = a;
    i_operand_b = b;
    i_op        = op;
    i_rd_addr   = rd;
    i_ready     = rdy;
    i_flush     = fl;
    i_rst_n     = rn;
    #2;
    if (!rn || fl) begin
      exp_q.delete();
    end else if (v && o_ready) begin
      exp_q.push_back('{res: ref_shift(a, b, op), rd: rd});
    end
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, rdy, 1'b0, 1'b1);
  endtask

  // Monitor: outputs checked against the scoreboard occupancy every cycle,
  // and data compared whenever a pop will take place at the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #1;
      if (mon_en) begin
        check("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
        check("o_ready", 32'(o_ready), 32'(exp_q.size() < 2));
        if (o_valid && i_ready && !i_flush && i_rst_n && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("o_result", o_result, e.res);
          check("o_rd_addr", 32'(o_rd_addr), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b, y_res;
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_operand_a = '0; i_operand_b = '0; i_op = '0; i_rd_addr = '0;

    // Reset
    drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_o_valid", 32'(o_valid), 32'h0);
    check("rst_o_ready", 32'(o_ready), 32'h1);
    check("rst_o_result", o_result, 32'h0);
    check("rst_o_rd_addr", 32'(o_rd_addr), 32'h0);
    mon_en = 1'b1;

    // SLL by 1
    drive(1'b1, 32'h8000_0001, 32'd1, 2'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check("sll1_valid", 32'(o_valid), 32'h1);
    check("sll1_result", o_result, 32'h0000_0002);
    check("sll1_rd", 32'(o_rd_addr), 32'd5);

    // SRA then SRL by 4
    drive(1'b1, 32'h8000_0000, 32'd4, 2'd2, 5'd1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'd4, 2'd1, 5'd2, 1'b1, 1'b0, 1'b1);
    check("sra4_result", o_result, 32'hF800_0000);
    idle(1'b1);
    check("srl4_result", o_result, 32'h0800_0000);
    idle(1'b1);

    // Backpressure: third op refused while full, then ordered drain
    drive(1'b1, 32'hC000_0001, 32'd31, 2'd2, 5'd10, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h1357_9BDF, 32'd0,  2'd1, 5'd11, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hABCD_EF01, 32'd16, 2'd0, 5'd12, 1'b0, 1'b0, 1'b1);
    check("bp_full_ready", 32'(o_ready), 32'h0);
    check("bp_full_head", o_result, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("bp_drained", 32'(o_valid), 32'h0);

    // Same-cycle accept and pop at count 1
    drive(1'b1, 32'h0000_00F0, 32'd4, 2'd1, 5'd20, 1'b0, 1'b0, 1'b1);
    a = 32'h8765_4321; b = 32'd8;
    y_res = ref_shift(a, b, 2'd2);
    drive(1'b1, a, b, 2'd2, 5'd21, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    check("acc_pop_valid", 32'(o_valid), 32'h1);
    check("acc_pop_ready", 32'(o_ready), 32'h1);
    check("acc_pop_head", o_result, y_res);
    idle(1'b1);
    idle(1'b1);

    // Flush while full with a same-cycle input
    drive(1'b1, 32'h1111_1111, 32'd1, 2'd0, 5'd3, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h2222_2222, 32'd2, 2'd0, 5'd4, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hDEAD_BEEF, 32'd0, 2'd3, 5'd31, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    check("flush_valid", 32'(o_valid), 32'h0);
    check("flush_ready", 32'(o_ready), 32'h1);
    idle(1'b1);

    // Reset with two entries buffered, then reserved op
    drive(1'b1, 32'h3333_3333, 32'd3, 2'd1, 5'd6, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h4444_4444, 32'd4, 2'd2, 5'd7, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h5555_5555, 32'd5, 2'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("rst2_valid", 32'(o_valid), 32'h0);
    check("rst2_result", o_result, 32'h0);
    drive(1'b1, 32'h1234_5678, 32'd7, 2'd3, 5'd9, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check("rsvd_result", o_result, 32'h1234_5678);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) << 5 : $urandom;
      drive(1'($urandom_range(0, 3) != 0), a, b, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 150) != 0));
    end

    for (int i = 0; i < 4; i++) idle(1'b1);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
